// File: rtl/fdtd_step_sched.sv
// fdtd_step_sched: FDTD leapfrog timestep scheduler.
// Sequences Hy/Ez load, calc, source and writeback for NUM_STEPS runs.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start_i, abort_i    run control pulses
//   num_steps_i         timesteps to run (sampled on accepted start)
//   src_en_i            enable source phase (sampled on accepted start)
//   ld_done_i           DMA buffer load complete
//   wrt_*_start_i       fdtd_acc calc complete (Hy / Ez / source)
//   mem_rd_end_i        DMA writeback complete
//   buf_*_start_o/_end_o  buffer load open/close pulses
//   calc_*_flg_o        calc start pulses
//   mem_rd_*_en_o       writeback phase levels
//   busy_o, done_o, err_o, step_cnt_o  status
// All outputs are registered and reflect the state entered at the same edge.
module fdtd_step_sched #(
  parameter int STEP_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [STEP_CNT_WIDTH-1:0] num_steps_i,
  input  logic                      src_en_i,
  input  logic                      ld_done_i,
  input  logic                      wrt_hy_start_i,
  input  logic                      wrt_ez_start_i,
  input  logic                      wrt_src_start_i,
  input  logic                      mem_rd_end_i,
  output logic                      buf_hy_start_o,
  output logic                      buf_ez_start_o,
  output logic                      buf_hy_end_o,
  output logic                      buf_ez_end_o,
  output logic                      calc_hy_flg_o,
  output logic                      calc_ez_flg_o,
  output logic                      calc_src_flg_o,
  output logic                      mem_rd_hy_en_o,
  output logic                      mem_rd_ez_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [STEP_CNT_WIDTH-1:0] step_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_HY,
    S_CA_HY,
    S_WB_HY,
    S_LD_EZ,
    S_CA_EZ,
    S_CA_SRC,
    S_WB_EZ,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  // Last watchdog value still allowed inside a wait state.
  localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                    r_state;
  logic [STEP_CNT_WIDTH-1:0] r_num;
  logic                      r_src;
  logic [STEP_CNT_WIDTH-1:0] r_step;
  logic [TIMEOUT_WIDTH-1:0]  r_wdog;

  logic r_buf_hy_start;
  logic r_buf_ez_start;
  logic r_buf_hy_end;
  logic r_buf_ez_end;
  logic r_calc_hy;
  logic r_calc_ez;
  logic r_calc_src;
  logic r_mem_hy;
  logic r_mem_ez;
  logic r_busy;
  logic r_done;
  logic r_err;

  state_t                    w_next;
  logic                      w_enter;
  logic [STEP_CNT_WIDTH-1:0] w_num;
  logic                      w_src;
  logic [STEP_CNT_WIDTH-1:0] w_step;
  logic [STEP_CNT_WIDTH-1:0] w_step_inc;
  logic                      w_wd_exp;
  logic                      w_wait;
  logic                      w_hy_end;
  logic                      w_ez_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_src   <= 1'b0;
      r_step  <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next;
      r_num   <= w_num;
      r_src   <= w_src;
      r_step  <= w_step;
      if (w_enter || !w_wait) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
      end
    end
  end

  assign w_wait = r_state inside {
    S_LD_HY, S_CA_HY, S_WB_HY,
    S_LD_EZ, S_CA_EZ, S_CA_SRC, S_WB_EZ
  };

  always_comb begin
    w_next     = r_state;
    w_enter    = 1'b0;
    w_num      = r_num;
    w_src      = r_src;
    w_step     = r_step;
    w_hy_end   = 1'b0;
    w_ez_end   = 1'b0;
    w_step_inc = r_step + STEP_CNT_WIDTH'(1);
    w_wd_exp   = (r_wdog == LP_WD_LAST);

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          w_enter = 1'b1;
          w_num   = num_steps_i;
          w_src   = src_en_i;
          w_step  = '0;
          if (num_steps_i == '0) begin
            w_next = S_DONE;
          end else begin
            w_next = S_LD_HY;
          end
        end
      end
      S_LD_HY: begin
        if (ld_done_i) begin
          w_next   = S_CA_HY;
          w_enter  = 1'b1;
          w_hy_end = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_CA_HY: begin
        if (wrt_hy_start_i) begin
          w_next  = S_WB_HY;
          w_enter = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_WB_HY: begin
        if (mem_rd_end_i) begin
          w_next  = S_LD_EZ;
          w_enter = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_LD_EZ: begin
        if (ld_done_i) begin
          w_next   = S_CA_EZ;
          w_enter  = 1'b1;
          w_ez_end = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_CA_EZ: begin
        if (wrt_ez_start_i) begin
          w_enter = 1'b1;
          if (r_src) begin
            w_next = S_CA_SRC;
          end else begin
            w_next = S_WB_EZ;
          end
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_CA_SRC: begin
        if (wrt_src_start_i) begin
          w_next  = S_WB_EZ;
          w_enter = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_WB_EZ: begin
        if (mem_rd_end_i) begin
          w_next  = S_NEXT;
          w_enter = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = S_ERR;
          w_enter = 1'b1;
        end
      end
      S_NEXT: begin
        w_enter = 1'b1;
        // Saturate at the target so the count can never wrap.
        if (r_step != r_num) begin
          w_step = w_step_inc;
        end
        if (w_step_inc == r_num || r_step == r_num) begin
          w_next = S_DONE;
        end else begin
          w_next = S_LD_HY;
        end
      end
      default: begin
        w_next  = S_IDLE;
        w_enter = 1'b1;
      end
    endcase

    // Abort overrides everything; the step count is kept for inspection.
    if (abort_i) begin
      w_next   = S_IDLE;
      w_enter  = 1'b1;
      w_num    = r_num;
      w_src    = r_src;
      w_step   = r_step;
      w_hy_end = 1'b0;
      w_ez_end = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf_hy_start <= 1'b0;
      r_buf_ez_start <= 1'b0;
      r_buf_hy_end   <= 1'b0;
      r_buf_ez_end   <= 1'b0;
      r_calc_hy      <= 1'b0;
      r_calc_ez      <= 1'b0;
      r_calc_src     <= 1'b0;
      r_mem_hy       <= 1'b0;
      r_mem_ez       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_buf_hy_start <= w_enter && (w_next == S_LD_HY);
      r_buf_ez_start <= w_enter && (w_next == S_LD_EZ);
      r_buf_hy_end   <= w_hy_end;
      r_buf_ez_end   <= w_ez_end;
      r_calc_hy      <= w_enter && (w_next == S_CA_HY);
      r_calc_ez      <= w_enter && (w_next == S_CA_EZ);
      r_calc_src     <= w_enter && (w_next == S_CA_SRC);
      r_mem_hy       <= (w_next == S_WB_HY);
      r_mem_ez       <= (w_next == S_WB_EZ);
      r_busy         <= !(w_next inside {S_IDLE, S_DONE, S_ERR});
      r_done         <= w_enter && (w_next == S_DONE);
      r_err          <= (w_next == S_ERR);
    end
  end

  assign buf_hy_start_o = r_buf_hy_start;
  assign buf_ez_start_o = r_buf_ez_start;
  assign buf_hy_end_o   = r_buf_hy_end;
  assign buf_ez_end_o   = r_buf_ez_end;
  assign calc_hy_flg_o  = r_calc_hy;
  assign calc_ez_flg_o  = r_calc_ez;
  assign calc_src_flg_o = r_calc_src;
  assign mem_rd_hy_en_o = r_mem_hy;
  assign mem_rd_ez_en_o = r_mem_ez;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign step_cnt_o     = r_step;

endmodule

// File: tb/tb_fdtd_step_sched.sv
// tb_fdtd_step_sched: directed bench for the FDTD timestep scheduler.
// Vector table plus hand sequences for responder runs, watchdog, abort, reset.
module tb_fdtd_step_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] num_steps_i = '0;
  logic        src_en_i = 1'b0;
  logic        ld_done_i = 1'b0;
  logic        wrt_hy_start_i = 1'b0;
  logic        wrt_ez_start_i = 1'b0;
  logic        wrt_src_start_i = 1'b0;
  logic        mem_rd_end_i = 1'b0;
  logic        buf_hy_start_o;
  logic        buf_ez_start_o;
  logic        buf_hy_end_o;
  logic        buf_ez_end_o;
  logic        calc_hy_flg_o;
  logic        calc_ez_flg_o;
  logic        calc_src_flg_o;
  logic        mem_rd_hy_en_o;
  logic        mem_rd_ez_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] step_cnt_o;

  fdtd_step_sched #(
    .STEP_CNT_WIDTH(16),
    .TIMEOUT_WIDTH (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .num_steps_i    (num_steps_i),
    .src_en_i       (src_en_i),
    .ld_done_i      (ld_done_i),
    .wrt_hy_start_i (wrt_hy_start_i),
    .wrt_ez_start_i (wrt_ez_start_i),
    .wrt_src_start_i(wrt_src_start_i),
    .mem_rd_end_i   (mem_rd_end_i),
    .buf_hy_start_o (buf_hy_start_o),
    .buf_ez_start_o (buf_ez_start_o),
    .buf_hy_end_o   (buf_hy_end_o),
    .buf_ez_end_o   (buf_ez_end_o),
    .calc_hy_flg_o  (calc_hy_flg_o),
    .calc_ez_flg_o  (calc_ez_flg_o),
    .calc_src_flg_o (calc_src_flg_o),
    .mem_rd_hy_en_o (mem_rd_hy_en_o),
    .mem_rd_ez_en_o (mem_rd_ez_en_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .step_cnt_o     (step_cnt_o)
  );

  always #5 CLK = ~CLK;

  localparam logic [11:0] O_BHS = 12'h800;
  localparam logic [11:0] O_BHE = 12'h400;
  localparam logic [11:0] O_CHY = 12'h200;
  localparam logic [11:0] O_MHY = 12'h100;
  localparam logic [11:0] O_BES = 12'h080;
  localparam logic [11:0] O_BEE = 12'h040;
  localparam logic [11:0] O_CEZ = 12'h020;
  localparam logic [11:0] O_CSR = 12'h010;
  localparam logic [11:0] O_MEZ = 12'h008;
  localparam logic [11:0] O_BSY = 12'h004;
  localparam logic [11:0] O_DON = 12'h002;
  localparam logic [11:0] O_ERR = 12'h001;

  localparam logic [6:0] T_NO = 7'h00;
  localparam logic [6:0] T_ST = 7'h40;
  localparam logic [6:0] T_AB = 7'h20;
  localparam logic [6:0] T_LD = 7'h10;
  localparam logic [6:0] T_HY = 7'h08;
  localparam logic [6:0] T_EZ = 7'h04;
  localparam logic [6:0] T_SR = 7'h02;
  localparam logic [6:0] T_WE = 7'h01;

  typedef struct {
    logic [6:0]  in;
    logic [15:0] n;
    logic        se;
    logic [11:0] eo;
    logic [15:0] es;
  } vec_t;

  vec_t tbl [17];

  int n_chk = 0;
  int n_err = 0;

  int   r_done;
  int   r_src;
  int   r_hys;
  int   r_bad_order;
  int   r_bad_step;
  logic r_timeout;

  function automatic logic [11:0] get_o();
    return {buf_hy_start_o, buf_hy_end_o, calc_hy_flg_o,
            mem_rd_hy_en_o, buf_ez_start_o, buf_ez_end_o,
            calc_ez_flg_o, calc_src_flg_o, mem_rd_ez_en_o,
            busy_o, done_o, err_o};
  endfunction

  function automatic vec_t mk(
    input logic [6:0] in, input logic [15:0] n,
    input logic se, input logic [11:0] eo,
    input logic [15:0] es);
    vec_t v;
    v.in = in;
    v.n  = n;
    v.se = se;
    v.eo = eo;
    v.es = es;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    start_i         = 1'b0;
    abort_i         = 1'b0;
    ld_done_i       = 1'b0;
    wrt_hy_start_i  = 1'b0;
    wrt_ez_start_i  = 1'b0;
    wrt_src_start_i = 1'b0;
    mem_rd_end_i    = 1'b0;
  endtask

  task automatic tick(input logic [6:0] b);
    start_i         = b[6];
    abort_i         = b[5];
    ld_done_i       = b[4];
    wrt_hy_start_i  = b[3];
    wrt_ez_start_i  = b[2];
    wrt_src_start_i = b[1];
    mem_rd_end_i    = b[0];
    @(posedge CLK);
    #1;
    clr_in();
  endtask

  // One iteration from LD_HY back to LD_HY, no source phase.
  task automatic fast_iter();
    tick(T_LD);
    tick(T_HY);
    tick(T_WE);
    tick(T_LD);
    tick(T_EZ);
    tick(T_WE);
    tick(T_NO);
  endtask

  // Responder: answers each phase dly cycles after its strobe.
  task automatic run_resp(input int dly, input int budget,
                          input logic exp_src);
    int          cd;
    int          kind;
    int          tail;
    logic        pm_hy;
    logic        pm_ez;
    logic        ezd;
    logic        srcs;
    logic [15:0] ps;
    cd = 0;
    kind = 0;
    tail = -1;
    pm_hy = 1'b0;
    pm_ez = 1'b0;
    ezd = 1'b0;
    srcs = 1'b0;
    ps = step_cnt_o;
    r_done = 0;
    r_src = 0;
    r_hys = 0;
    r_bad_order = 0;
    r_bad_step = 0;
    for (int i = 0; i < budget && tail != 0; i++) begin
      @(posedge CLK);
      #1;
      clr_in();
      if (done_o) begin
        r_done++;
        if (tail < 0) tail = 5;
      end
      if (tail > 0) tail--;
      if (buf_hy_start_o) r_hys++;
      if (calc_src_flg_o) begin
        r_src++;
        if (!ezd) r_bad_order++;
        srcs = 1'b1;
      end
      if (mem_rd_ez_en_o && !pm_ez) begin
        if (srcs != exp_src) r_bad_order++;
        ezd = 1'b0;
        srcs = 1'b0;
      end
      if (step_cnt_o != ps) begin
        if (step_cnt_o != ps + 16'd1) r_bad_step++;
        ps = step_cnt_o;
      end
      if (buf_hy_start_o || buf_ez_start_o) begin
        kind = 1;
        cd = dly;
      end else if (calc_hy_flg_o) begin
        kind = 2;
        cd = dly;
      end else if (calc_ez_flg_o) begin
        kind = 3;
        cd = dly;
      end else if (calc_src_flg_o) begin
        kind = 4;
        cd = dly;
      end else if ((mem_rd_hy_en_o && !pm_hy) ||
                   (mem_rd_ez_en_o && !pm_ez)) begin
        kind = 5;
        cd = dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          case (kind)
            1: ld_done_i = 1'b1;
            2: wrt_hy_start_i = 1'b1;
            3: begin
              wrt_ez_start_i = 1'b1;
              ezd = 1'b1;
            end
            4: wrt_src_start_i = 1'b1;
            5: mem_rd_end_i = 1'b1;
            default: ;
          endcase
          kind = 0;
        end
      end
      pm_hy = mem_rd_hy_en_o;
      pm_ez = mem_rd_ez_en_o;
    end
    r_timeout = (tail != 0);
  endtask

  initial begin
    tbl[0]  = mk(T_ST, 16'd1, 1'b1, O_BHS | O_BSY, 16'd0);
    tbl[1]  = mk(T_LD, 16'd0, 1'b0, O_BHE | O_CHY | O_BSY, 16'd0);
    tbl[2]  = mk(T_HY, 16'd0, 1'b0, O_MHY | O_BSY, 16'd0);
    tbl[3]  = mk(T_LD, 16'd0, 1'b0, O_MHY | O_BSY, 16'd0);
    tbl[4]  = mk(T_WE, 16'd0, 1'b0, O_BES | O_BSY, 16'd0);
    tbl[5]  = mk(T_LD, 16'd0, 1'b0, O_BEE | O_CEZ | O_BSY, 16'd0);
    tbl[6]  = mk(T_EZ, 16'd0, 1'b0, O_CSR | O_BSY, 16'd0);
    tbl[7]  = mk(T_SR, 16'd0, 1'b0, O_MEZ | O_BSY, 16'd0);
    tbl[8]  = mk(T_WE, 16'd0, 1'b0, O_BSY, 16'd0);
    tbl[9]  = mk(T_NO, 16'd0, 1'b0, O_DON, 16'd1);
    tbl[10] = mk(T_NO, 16'd0, 1'b0, 12'h000, 16'd1);
    tbl[11] = mk(T_ST, 16'd0, 1'b0, O_DON, 16'd0);
    tbl[12] = mk(T_NO, 16'd0, 1'b0, 12'h000, 16'd0);
    tbl[13] = mk(T_ST, 16'd2, 1'b0, O_BHS | O_BSY, 16'd0);
    tbl[14] = mk(T_ST, 16'd5, 1'b0, O_BSY, 16'd0);
    tbl[15] = mk(T_ST | T_AB, 16'd3, 1'b0, 12'h000, 16'd0);
    tbl[16] = mk(T_NO, 16'd0, 1'b0, 12'h000, 16'd0);

    RST = 1'b1;
    tick(T_NO);
    tick(T_NO);
    chk("reset_out", get_o(), 12'h000);
    chk("reset_step", step_cnt_o, 16'd0);
    RST = 1'b0;
    tick(T_NO);
    chk("idle_out", get_o(), 12'h000);

    for (int i = 0; i < 17; i++) begin
      num_steps_i = tbl[i].n;
      src_en_i    = tbl[i].se;
      tick(tbl[i].in);
      chk($sformatf("vec%0d_out", i), get_o(), tbl[i].eo);
      chk($sformatf("vec%0d_step", i), step_cnt_o, tbl[i].es);
    end

    // Three steps, no source, 5-cycle responders.
    num_steps_i = 16'd3;
    src_en_i    = 1'b0;
    start_i     = 1'b1;
    run_resp(5, 1000, 1'b0);
    chk("t1_timeout", r_timeout, 1'b0);
    chk("t1_done_cnt", r_done, 1);
    chk("t1_src_cnt", r_src, 0);
    chk("t1_hy_loads", r_hys, 3);
    chk("t1_step", step_cnt_o, 16'd3);
    chk("t1_step_seq", r_bad_step, 0);
    chk("t1_order", r_bad_order, 0);
    chk("t1_busy", busy_o, 1'b0);

    // Two steps with source phase.
    num_steps_i = 16'd2;
    src_en_i    = 1'b1;
    start_i     = 1'b1;
    run_resp(3, 1000, 1'b1);
    chk("t2_timeout", r_timeout, 1'b0);
    chk("t2_done_cnt", r_done, 1);
    chk("t2_src_cnt", r_src, 2);
    chk("t2_hy_loads", r_hys, 2);
    chk("t2_step", step_cnt_o, 16'd2);
    chk("t2_order", r_bad_order, 0);

    // Watchdog in WB_HY.
    num_steps_i = 16'd1;
    src_en_i    = 1'b0;
    tick(T_ST);
    tick(T_LD);
    tick(T_HY);
    chk("t4_wb_entry", get_o(), O_MHY | O_BSY);
    for (int j = 1; j <= 100; j++) begin
      @(posedge CLK);
      #1;
      if (j == 99) chk("t4_wb_99", get_o(), O_MHY | O_BSY);
      if (j == 100) chk("t4_err_100", get_o(), O_ERR);
    end
    tick(T_NO);
    tick(T_LD);
    chk("t4_err_held", get_o(), O_ERR);
    num_steps_i = 16'd0;
    tick(T_ST);
    chk("t4_restart", get_o(), O_DON);

    // Abort in CA_EZ together with its completion.
    num_steps_i = 16'd2;
    tick(T_ST);
    fast_iter();
    chk("t5_iter2", get_o(), O_BHS | O_BSY);
    chk("t5_step1", step_cnt_o, 16'd1);
    tick(T_LD);
    tick(T_HY);
    tick(T_WE);
    tick(T_LD);
    chk("t5_ca_ez", get_o(), O_BEE | O_CEZ | O_BSY);
    num_steps_i = 16'd9;
    tick(T_ST);
    chk("t5_busy_start", get_o(), O_BSY);
    chk("t5_busy_step", step_cnt_o, 16'd1);
    tick(T_AB | T_EZ);
    chk("t5_abort_out", get_o(), 12'h000);
    chk("t5_abort_step", step_cnt_o, 16'd1);
    tick(T_WE);
    chk("t5_idle_after", get_o(), 12'h000);

    // Spurious ld_done in CA_HY, then reset in LD_EZ.
    num_steps_i = 16'd3;
    tick(T_ST);
    fast_iter();
    tick(T_LD);
    chk("t6_ca_hy", get_o(), O_BHE | O_CHY | O_BSY);
    tick(T_LD);
    chk("t6_spurious", get_o(), O_BSY);
    tick(T_HY);
    chk("t6_wb_hy", get_o(), O_MHY | O_BSY);
    tick(T_WE);
    chk("t6_ld_ez", get_o(), O_BES | O_BSY);
    chk("t6_step_pre", step_cnt_o, 16'd1);
    RST = 1'b1;
    tick(T_NO);
    chk("t6_rst_out", get_o(), 12'h000);
    chk("t6_rst_step", step_cnt_o, 16'd0);
    RST = 1'b0;
    tick(T_LD);
    chk("t6_post_rst", get_o(), 12'h000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
